// File: rtl/stream_checker.sv
// Consumer-side checker for the clock_2 output stream: verifies timer (+1) or Fibonacci sequences.
// Optional even-parity check on every accepted word when PARITY_CHECK_EN is defined.
module stream_checker #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ERR_W  = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        gen_mod,
    input  logic              data_2_valid,
    input  logic [DATA_W-1:0] data_2,
    input  logic              parity_in,
    input  logic              clear,
    output logic              locked,
    output logic              mismatch,
    output logic              err_sticky,
    output logic [ERR_W-1:0]  err_count,
    output logic [CNT_W-1:0]  word_count
);

    localparam logic [1:0] MODE_TIMER = 2'b01;
    localparam logic [1:0] MODE_FIB   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SYNC1 = 2'd1,
        S_SYNC2 = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [1:0]        mode_q, mode_n;
    logic [DATA_W-1:0] prev_a, prev_a_n;
    logic [DATA_W-1:0] prev_b, prev_b_n;
    logic              accept;
    logic              seq_err;
    logic              par_err;
    logic              mis_n;
    logic [DATA_W:0]   fib_sum;
    logic [DATA_W-1:0] timer_exp;

    assign fib_sum   = {1'b0, prev_a} + {1'b0, prev_b};
    assign timer_exp = prev_b + DATA_W'(1);

`ifdef PARITY_CHECK_EN
    assign par_err = accept && (^{data_2, parity_in});
`else
    logic unused_parity;
    assign unused_parity = parity_in;
    assign par_err       = 1'b0;
`endif

    assign mis_n = seq_err | par_err;

    always_comb begin
        state_n  = state;
        mode_n   = mode_q;
        prev_a_n = prev_a;
        prev_b_n = prev_b;
        accept   = 1'b0;
        seq_err  = 1'b0;
        if (state == S_IDLE) begin
            if (gen_mod == MODE_TIMER || gen_mod == MODE_FIB) begin
                mode_n  = gen_mod;
                state_n = S_SYNC1;
            end
        end else if (gen_mod != mode_q) begin
            // mode change: drop the word seen this cycle and fall back to idle
            state_n = S_IDLE;
        end else if (data_2_valid) begin
            accept   = 1'b1;
            prev_b_n = data_2;
            unique case (state)
                S_SYNC1: state_n = (mode_q == MODE_TIMER) ? S_CHECK : S_SYNC2;
                S_SYNC2: begin
                    prev_a_n = prev_b;
                    state_n  = S_CHECK;
                end
                S_CHECK: begin
                    if (mode_q == MODE_TIMER) begin
                        seq_err = (data_2 != timer_exp);
                    end else if (fib_sum[DATA_W]) begin
                        // producer restarts after overflow; this word is unchecked
                        state_n = S_SYNC2;
                    end else if (data_2 == fib_sum[DATA_W-1:0]) begin
                        prev_a_n = prev_b;
                    end else begin
                        seq_err = 1'b1;
                        state_n = S_SYNC2;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            mode_q     <= '0;
            prev_a     <= '0;
            prev_b     <= '0;
            locked     <= 1'b0;
            mismatch   <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
            word_count <= '0;
        end else begin
            state    <= state_n;
            mode_q   <= mode_n;
            prev_a   <= prev_a_n;
            prev_b   <= prev_b_n;
            locked   <= (state_n == S_CHECK);
            mismatch <= mis_n && !clear;
            if (clear) begin
                err_sticky <= 1'b0;
                err_count  <= '0;
                word_count <= '0;
            end else begin
                if (mis_n) begin
                    err_sticky <= 1'b1;
                    if (err_count != '1) err_count <= err_count + ERR_W'(1);
                end
                if (accept) word_count <= word_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_stream_checker.sv
// Directed self-checking bench for stream_checker: timer, wrap, fibonacci, overflow, mode/clear, parity, reset.
module tb_stream_checker;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  gen_mod;
    logic        data_2_valid;
    logic [15:0] data_2;
    logic        parity_in;
    logic        clear;
    logic        locked;
    logic        mismatch;
    logic        err_sticky;
    logic [7:0]  err_count;
    logic [15:0] word_count;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

`ifdef PARITY_CHECK_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    stream_checker #(.DATA_W(16), .ERR_W(8), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .gen_mod(gen_mod),
        .data_2_valid(data_2_valid), .data_2(data_2), .parity_in(parity_in),
        .clear(clear), .locked(locked), .mismatch(mismatch),
        .err_sticky(err_sticky), .err_count(err_count), .word_count(word_count)
    );

    always #5 clock = ~clock;

    // drive one valid word, outputs are observed 1 time unit after the sampling edge
    task automatic word(input logic [15:0] d, input bit bad_par);
        @(negedge clock);
        data_2       = d;
        parity_in    = (^d) ^ bad_par;
        data_2_valid = 1'b1;
        @(posedge clock);
        #1;
        data_2_valid = 1'b0;
    endtask

    task automatic set_mode(input logic [1:0] m);
        @(negedge clock);
        gen_mod = m;
        @(posedge clock);
        #1;
    endtask

    task automatic do_clear();
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
    endtask

    task automatic restart(input logic [1:0] m);
        set_mode(2'b00);
        do_clear();
        set_mode(m);
    endtask

    task automatic test_reset();
        reset = 1'b0; gen_mod = 2'b00; data_2_valid = 1'b0;
        data_2 = '0; parity_in = 1'b0; clear = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_total++;
        if ({locked, mismatch, err_sticky, err_count, word_count} !== 27'd0) begin
            $display("FAIL reset_outputs got %0h exp 0",
                     {locked, mismatch, err_sticky, err_count, word_count});
        end else n_pass++;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_timer();
        set_mode(2'b01);
        word(16'd5, 0);
        n_total++;
        if (locked !== 1'b1) $display("FAIL timer_lock got %b exp 1", locked); else n_pass++;
        for (int i = 6; i <= 8; i++) begin
            word(16'(i), 0);
            n_total++;
            if (mismatch !== 1'b0) $display("FAIL timer_word%0d got %b exp 0", i, mismatch);
            else n_pass++;
        end
        n_total++;
        if (err_count !== 8'd0) $display("FAIL timer_errs got %0d exp 0", err_count); else n_pass++;
        n_total++;
        if (word_count !== 16'd4) $display("FAIL timer_count got %0d exp 4", word_count); else n_pass++;
    endtask

    task automatic test_timer_wrap();
        restart(2'b01);
        word(16'hFFFE, 0);
        word(16'hFFFF, 0);
        n_total++;
        if (mismatch !== 1'b0) $display("FAIL wrap_ffff got %b exp 0", mismatch); else n_pass++;
        word(16'h0000, 0);
        n_total++;
        if (mismatch !== 1'b0) $display("FAIL wrap_0000 got %b exp 0", mismatch); else n_pass++;
        word(16'h0005, 0);
        n_total++;
        if ({mismatch, err_sticky, err_count} !== {1'b1, 1'b1, 8'd1})
            $display("FAIL wrap_bad got m=%b s=%b c=%0d exp m=1 s=1 c=1", mismatch, err_sticky, err_count);
        else n_pass++;
        @(posedge clock); #1;
        n_total++;
        if (mismatch !== 1'b0) $display("FAIL wrap_pulse got %b exp 0", mismatch); else n_pass++;
    endtask

    task automatic test_fib();
        logic [15:0] seq [6] = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8};
        restart(2'b10);
        word(seq[0], 0);
        n_total++;
        if (locked !== 1'b0) $display("FAIL fib_sync1 got %b exp 0", locked); else n_pass++;
        word(seq[1], 0);
        n_total++;
        if (locked !== 1'b1) $display("FAIL fib_lock got %b exp 1", locked); else n_pass++;
        for (int i = 2; i < 6; i++) begin
            word(seq[i], 0);
            n_total++;
            if (mismatch !== 1'b0) $display("FAIL fib_word%0d got %b exp 0", i, mismatch);
            else n_pass++;
        end
        word(16'd14, 0);
        n_total++;
        if ({mismatch, locked, err_count} !== {1'b1, 1'b0, 8'd1})
            $display("FAIL fib_bad got m=%b l=%b c=%0d exp m=1 l=0 c=1", mismatch, locked, err_count);
        else n_pass++;
        n_total++;
        if (word_count !== 16'd7) $display("FAIL fib_count got %0d exp 7", word_count); else n_pass++;
    endtask

    task automatic test_fib_overflow();
        set_mode(2'b00);
        set_mode(2'b10);
        word(16'd28657, 0);
        word(16'd46368, 0);
        n_total++;
        if (locked !== 1'b1) $display("FAIL ovf_lock got %b exp 1", locked); else n_pass++;
        word(16'd12345, 0);
        n_total++;
        if ({mismatch, locked, err_count} !== {1'b0, 1'b0, 8'd1})
            $display("FAIL ovf_skip got m=%b l=%b c=%0d exp m=0 l=0 c=1", mismatch, locked, err_count);
        else n_pass++;
        word(16'd7, 0);
        word(16'd12352, 0);
        n_total++;
        if ({mismatch, locked} !== 2'b01)
            $display("FAIL ovf_resync got m=%b l=%b exp m=0 l=1", mismatch, locked);
        else n_pass++;
    endtask

    task automatic test_mode_clear();
        @(negedge clock);
        gen_mod = 2'b00; data_2 = 16'd999; parity_in = ^data_2; data_2_valid = 1'b1;
        @(posedge clock); #1;
        n_total++;
        if ({locked, mismatch, err_count, word_count} !== {1'b0, 1'b0, 8'd1, 16'd12})
            $display("FAIL mode_drop got l=%b m=%b c=%0d w=%0d exp l=0 m=0 c=1 w=12",
                     locked, mismatch, err_count, word_count);
        else n_pass++;
        @(posedge clock); #1;
        data_2_valid = 1'b0;
        n_total++;
        if (word_count !== 16'd12) $display("FAIL idle_valid got %0d exp 12", word_count); else n_pass++;
        do_clear();
        n_total++;
        if ({err_sticky, err_count, word_count} !== 25'd0)
            $display("FAIL clear got s=%b c=%0d w=%0d exp 0", err_sticky, err_count, word_count);
        else n_pass++;
        set_mode(2'b01);
        word(16'd0, 0);
        word(16'd0, 0);
        n_total++;
        if (err_count !== 8'd1) $display("FAIL sat_first got %0d exp 1", err_count); else n_pass++;
        for (int i = 1; i < 260; i++) word(16'd0, 0);
        n_total++;
        if ({err_sticky, err_count, word_count} !== {1'b1, 8'd255, 16'd261})
            $display("FAIL saturate got s=%b c=%0d w=%0d exp s=1 c=255 w=261",
                     err_sticky, err_count, word_count);
        else n_pass++;
    endtask

    task automatic test_parity();
        restart(2'b01);
        word(16'd1, 0);
        word(16'd2, 1);
        n_total++;
        if (mismatch !== PAR_ON) $display("FAIL par_word2 got %b exp %b", mismatch, PAR_ON); else n_pass++;
        word(16'd3, 0);
        n_total++;
        if (mismatch !== 1'b0) $display("FAIL par_word3 got %b exp 0", mismatch); else n_pass++;
        n_total++;
        if (err_count !== 8'(PAR_ON)) $display("FAIL par_errs got %0d exp %0d", err_count, PAR_ON);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        word(16'd4, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_total++;
        if ({locked, word_count} !== 17'd0)
            $display("FAIL rst_async got l=%b w=%0d exp 0", locked, word_count);
        else n_pass++;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        word(16'd10, 0);
        n_total++;
        if ({locked, mismatch, word_count} !== {1'b1, 1'b0, 16'd1})
            $display("FAIL rst_resync got l=%b m=%b w=%0d exp l=1 m=0 w=1", locked, mismatch, word_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_timer();
        test_timer_wrap();
        test_fib();
        test_fib_overflow();
        test_mode_clear();
        test_parity();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
